// File: rtl/regfile_bank.sv
// Integer register file: 2 combinational read ports with write bypass, 1 write port, x0 = 0.
// Latency: reads 0 cycles, write visible next edge; optional REGFILE_DBG_PORT_EN debug read, 1 cycle.
// Backpressure: none; ready_o low during the post-reset clear sweep, writes dropped until it rises.
module regfile_bank #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o
`endif
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              ready_nxt;
  logic              clr_en, wr_en;
  logic [DATA_W-1:0] mem [1:NUM_REGS-1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= INIT;
      clr_cnt <= ADDR_W'(1);
      ready_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ready_o <= ready_nxt;
    end
  end

  // Counter parks on the last index once the sweep finishes.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready_nxt   = ready_o;
    case (state)
      INIT: begin
        if (clr_cnt == LAST_IDX) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt   = INIT;
        clr_cnt_nxt = ADDR_W'(1);
        ready_nxt   = 1'b0;
      end
    endcase
  end

  assign clr_en = rst_n_i && (state == INIT);
  assign wr_en  = rst_n_i && (state == RUN) && we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Bypass lets decode see the value write-back is committing this cycle.
  assign rdata1_o = (!ready_o || !re1_i || (raddr1_i == '0)) ? '0 :
                    (we_i && (waddr_i == raddr1_i))          ? wdata_i :
                                                               mem[raddr1_i];

  assign rdata2_o = (!ready_o || !re2_i || (raddr2_i == '0)) ? '0 :
                    (we_i && (waddr_i == raddr2_i))          ? wdata_i :
                                                               mem[raddr2_i];

`ifdef REGFILE_DBG_PORT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dbg_rdata_o <= '0;
    end else if ((state == RUN) && (dbg_raddr_i != '0)) begin
      dbg_rdata_o <= mem[dbg_raddr_i];
    end else begin
      dbg_rdata_o <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: read expectations go through a scoreboard queue.
module tb_regfile_bank;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
`ifdef REGFILE_DBG_PORT_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`endif

  logic [31:0] sb_q [$];
  logic [31:0] model_mem [32];
  bit          model_ready;
  int          checks;
  int          errors;

  regfile_bank dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ready_o    (ready),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .re1_i      (re1),
    .raddr1_i   (raddr1),
    .rdata1_o   (rdata1),
    .re2_i      (re2),
    .raddr2_i   (raddr2),
    .rdata2_o   (rdata2)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_raddr_i(dbg_raddr),
    .dbg_rdata_o(dbg_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!model_ready || !re || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model_mem[a];
  endfunction

  // Advance one edge, applying to the model whatever that edge commits.
  task automatic step();
    if (rst_n && model_ready && we && waddr != 5'd0) model_mem[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", ready);
    end
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_ready = 0;
    rst_n = 1'b1;
    re1 = 1'b1;
    raddr1 = 5'd5;
    for (int e = 1; e <= 31; e++) begin
      step();
      checks++;
      if (ready !== (e == 31)) begin
        errors++;
        $display("FAIL init_ready edge %0d got %b exp %b", e, ready, (e == 31));
      end
      if (e == 10) begin
        sb_q.push_back(exp_rd(re1, raddr1));
        e1 = sb_q.pop_front();
        checks++;
        if (rdata1 !== e1) begin
          errors++;
          $display("FAIL init_read got %h exp %h", rdata1, e1);
        end
      end
    end
    model_ready = 1;
    re2 = 1'b1;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a + 1);
      sb_q.push_back(exp_rd(re1, raddr1));
      sb_q.push_back(exp_rd(re2, raddr2));
      #1;
      e1 = sb_q.pop_front();
      e2 = sb_q.pop_front();
      checks += 2;
      if (rdata1 !== e1) begin
        errors++;
        $display("FAIL cleared_p1 addr %0d got %h exp %h", a, rdata1, e1);
      end
      if (rdata2 !== e2) begin
        errors++;
        $display("FAIL cleared_p2 addr %0d got %h exp %h", raddr2, rdata2, e2);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e1;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0;
    re1 = 1'b1; raddr1 = 5'd5;
    sb_q.push_back(32'hDEADBEEF);
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL basic_rd got %h exp %h", rdata1, e1);
    end
    re1 = 1'b0;
    sb_q.push_back(exp_rd(re1, raddr1));
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL re_low got %h exp %h", rdata1, e1);
    end
    re1 = 1'b1;
  endtask

  task automatic test_bypass();
    logic [31:0] e1, e2;
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000AAAA;
    step();
    wdata = 32'h00001234;
    raddr1 = 5'd7; raddr2 = 5'd7; re1 = 1'b1; re2 = 1'b1;
    sb_q.push_back(32'h00001234);
    sb_q.push_back(32'h00001234);
    #1;
    e1 = sb_q.pop_front();
    e2 = sb_q.pop_front();
    checks += 2;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL bypass_p1 got %h exp %h", rdata1, e1);
    end
    if (rdata2 !== e2) begin
      errors++;
      $display("FAIL bypass_p2 got %h exp %h", rdata2, e2);
    end
    step();
    we = 1'b0;
    sb_q.push_back(exp_rd(re1, raddr1));
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL bypass_commit got %h exp %h", rdata1, e1);
    end
  endtask

  task automatic test_x0();
    logic [31:0] e1, e2;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    raddr1 = 5'd0; raddr2 = 5'd0; re1 = 1'b1; re2 = 1'b1;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h0);
    #1;
    e1 = sb_q.pop_front();
    e2 = sb_q.pop_front();
    checks += 2;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL x0_same_p1 got %h exp %h", rdata1, e1);
    end
    if (rdata2 !== e2) begin
      errors++;
      $display("FAIL x0_same_p2 got %h exp %h", rdata2, e2);
    end
    step();
    we = 1'b0;
    sb_q.push_back(32'h0);
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL x0_next got %h exp %h", rdata1, e1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    re1 = 1'b1; re2 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = $urandom;
      raddr1 = 5'(i); raddr2 = 5'(i - 1);
      sb_q.push_back(exp_rd(re1, raddr1));
      sb_q.push_back(exp_rd(re2, raddr2));
      #1;
      e1 = sb_q.pop_front();
      e2 = sb_q.pop_front();
      checks += 2;
      if (rdata1 !== e1) begin
        errors++;
        $display("FAIL b2b_bypass addr %0d got %h exp %h", i, rdata1, e1);
      end
      if (rdata2 !== e2) begin
        errors++;
        $display("FAIL b2b_prev addr %0d got %h exp %h", i - 1, rdata2, e2);
      end
      step();
    end
    we = 1'b0;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(32 - a);
      sb_q.push_back(exp_rd(re1, raddr1));
      sb_q.push_back(exp_rd(re2, raddr2));
      #1;
      e1 = sb_q.pop_front();
      e2 = sb_q.pop_front();
      checks += 2;
      if (rdata1 !== e1) begin
        errors++;
        $display("FAIL b2b_rd_p1 addr %0d got %h exp %h", a, rdata1, e1);
      end
      if (rdata2 !== e2) begin
        errors++;
        $display("FAIL b2b_rd_p2 addr %0d got %h exp %h", raddr2, rdata2, e2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e1;
    int n;
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000A5A5;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
    sb_q.push_back(exp_rd(re1, raddr1));
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL mid_pre got %h exp %h", rdata1, e1);
    end
    rst_n = 1'b0; we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    step();
    model_ready = 0;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    we = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready got %b exp 0", ready);
    end
    sb_q.push_back(exp_rd(re1, raddr1));
    #1;
    e1 = sb_q.pop_front();
    checks++;
    if (rdata1 !== e1) begin
      errors++;
      $display("FAIL mid_rd0 got %h exp %h", rdata1, e1);
    end
    rst_n = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h77;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (ready === 1'b1) break;
    end
    we = 1'b0;
    checks++;
    if (n != 31 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_len got %0d edges ready %b exp 31 edges ready 1", n, ready);
    end
    model_ready = 1;
    for (int k = 0; k < 3; k++) begin
      raddr1 = (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd6;
      sb_q.push_back(exp_rd(re1, raddr1));
      #1;
      e1 = sb_q.pop_front();
      checks++;
      if (rdata1 !== e1) begin
        errors++;
        $display("FAIL mid_post addr %0d got %h exp %h", raddr1, rdata1, e1);
      end
    end
  endtask

`ifdef REGFILE_DBG_PORT_EN
  task automatic test_dbg();
    logic [31:0] e1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    step();
    we = 1'b0;
    dbg_raddr = 5'd9;
    sb_q.push_back(model_mem[9]);
    step();
    e1 = sb_q.pop_front();
    checks++;
    if (dbg_rdata !== e1) begin
      errors++;
      $display("FAIL dbg_rd got %h exp %h", dbg_rdata, e1);
    end
    dbg_raddr = 5'd0;
    sb_q.push_back(32'h0);
    step();
    e1 = sb_q.pop_front();
    checks++;
    if (dbg_rdata !== e1) begin
      errors++;
      $display("FAIL dbg_x0 got %h exp %h", dbg_rdata, e1);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_raddr = '0;
`endif
    model_ready = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_back_to_back();
`ifdef REGFILE_DBG_PORT_EN
    test_dbg();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
